// File: rtl/multi_spi_tx.sv
// multi_spi_tx: nibble-wide serializer for one channel of the select-addressed MultiSPI link.
// A captured word leaves MSB nibble first, one nibble per host beat addressed to CHAN_ID.
// Outputs are registers updated alongside the state, so they never depend on inputs directly.
module multi_spi_tx #(
    parameter int         REGSIZE = 32,
    parameter logic [1:0] CHAN_ID = 2'd1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [REGSIZE-1:0] data_in,
    input  logic [1:0]         S,
    input  logic               rd,
    output logic [3:0]         O,
    output logic               o_valid,
    output logic               busy,
    output logic               done
);

    localparam int NIB = REGSIZE / 4;
    localparam int CW  = $clog2(NIB) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [REGSIZE-1:0] shreg;
    logic [CW-1:0]      cnt;
    logic               beat;

    // A beat is a host strobe addressed to this channel; strobes for other channels are ignored.
    assign beat = rd && (S == CHAN_ID);

    // Transfer FSM; O/o_valid/busy/done are loaded with the values the next state presents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            O       <= 4'h0;
            o_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    O       <= 4'h0;
                    o_valid <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    // A strobe arriving with load consumes nothing: the word is only just captured.
                    if (load) begin
                        shreg   <= data_in;
                        cnt     <= CW'(NIB);
                        O       <= data_in[REGSIZE-1 -: 4];
                        o_valid <= 1'b1;
                        busy    <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (beat) begin
                        shreg <= shreg << 4;
                        cnt   <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            O       <= 4'h0;
                            o_valid <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            O <= shreg[REGSIZE-5 -: 4];
                        end
                    end
                end
                DONE: begin
                    O       <= 4'h0;
                    o_valid <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    O       <= 4'h0;
                    o_valid <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_spi_tx.sv
// tb_multi_spi_tx: directed checks of multi_spi_tx (32-bit/chan 1 and 128-bit/chan 3 instances).
module tb_multi_spi_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] data_in;
    logic [1:0]  S;
    logic        rd;
    logic [3:0]  O;
    logic        o_valid;
    logic        busy;
    logic        done;

    logic         load5;
    logic [127:0] data5;
    logic [1:0]   S5;
    logic         rd5;
    logic [3:0]   O5;
    logic         o_valid5;
    logic         busy5;
    logic         done5;

    int total = 0;
    int bad   = 0;

    multi_spi_tx #(.REGSIZE(32), .CHAN_ID(2'd1)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .S(S), .rd(rd),
        .O(O), .o_valid(o_valid), .busy(busy), .done(done)
    );

    multi_spi_tx #(.REGSIZE(128), .CHAN_ID(2'd3)) dut128 (
        .clk(clk), .rst(rst), .load(load5), .data_in(data5), .S(S5), .rd(rd5),
        .O(O5), .o_valid(o_valid5), .busy(busy5), .done(done5)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] nib32(input logic [31:0] w, input int k);
        return w[31-4*k -: 4];
    endfunction

    logic [31:0]  w;
    logic [127:0] word5;
    logic [127:0] got5;
    int           beats5;
    int           dones5;
    int           cyc;

    initial begin
        rst = 1'b1; load = 1'b0; data_in = '0; S = 2'd0; rd = 1'b0;
        load5 = 1'b0; data5 = '0; S5 = 2'd0; rd5 = 1'b0;
        tick();
        tick();
        check("rst_O", O, 4'h0);
        check("rst_valid", o_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;
        tick();

        // Test 1: continuous beats on 0xDEADBEEF
        w = 32'hDEADBEEF;
        load = 1'b1; data_in = w;
        tick();
        load = 1'b0; S = 2'd1; rd = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("t1_nib", O, nib32(w, k));
            check("t1_valid", o_valid, 1'b1);
            check("t1_nodone", done, 1'b0);
            tick();
        end
        rd = 1'b0;
        check("t1_done", done, 1'b1);
        check("t1_valid_off", o_valid, 1'b0);
        check("t1_O_zero", O, 4'h0);
        check("t1_busy_done", busy, 1'b1);
        tick();
        check("t1_idle_busy", busy, 1'b0);
        check("t1_done_pulse", done, 1'b0);

        // Test 2: strobes for another channel are ignored, then pulsed beats with gaps
        w = 32'h12345678;
        load = 1'b1; data_in = w;
        tick();
        load = 1'b0; S = 2'd2; rd = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2_hold", O, 4'h1);
            check("t2_hold_valid", o_valid, 1'b1);
        end
        S = 2'd1;
        for (int k = 0; k < 8; k++) begin
            rd = 1'b0;
            tick();
            check("t2_nib", O, nib32(w, k));
            check("t2_nodone", done, 1'b0);
            rd = 1'b1;
            tick();
        end
        rd = 1'b0;
        check("t2_done", done, 1'b1);
        tick();
        check("t2_idle", busy, 1'b0);

        // Test 3: load during SEND is ignored
        w = 32'h13579BDF;
        load = 1'b1; data_in = w;
        tick();
        load = 1'b0; S = 2'd1; rd = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        rd = 1'b0; load = 1'b1; data_in = 32'hFFFFFFFF;
        tick();
        load = 1'b0; rd = 1'b1;
        for (int k = 3; k < 8; k++) begin
            check("t3_nib", O, nib32(w, k));
            tick();
        end
        rd = 1'b0;
        check("t3_done", done, 1'b1);
        tick();
        check("t3_idle", busy, 1'b0);

        // Test 4: reset mid-transfer, then a fresh word
        w = 32'hCAFEF00D;
        load = 1'b1; data_in = w;
        tick();
        load = 1'b0; rd = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        rd = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_O", O, 4'h0);
        check("t4_valid", o_valid, 1'b0);
        check("t4_busy", busy, 1'b0);
        check("t4_done", done, 1'b0);
        tick();
        check("t4_nodone", done, 1'b0);
        w = 32'hA5A5A5A5;
        load = 1'b1; data_in = w;
        tick();
        load = 1'b0; rd = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("t4_nib", O, nib32(w, k));
            tick();
        end
        rd = 1'b0;
        check("t4_done2", done, 1'b1);
        tick();

        // Test 6: load and beat together in IDLE consume nothing
        w = 32'h0F1E2D3C;
        load = 1'b1; rd = 1'b1; S = 2'd1; data_in = w;
        tick();
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("t6_nib", O, nib32(w, k));
            check("t6_nodone", done, 1'b0);
            tick();
        end
        rd = 1'b0;
        check("t6_done", done, 1'b1);
        tick();
        check("t6_idle", busy, 1'b0);

        // Test 5: 128-bit channel 3, random strobes and selects
        word5 = {$urandom(), $urandom(), $urandom(), $urandom()};
        got5 = '0; beats5 = 0; dones5 = 0;
        load5 = 1'b1; data5 = word5;
        tick();
        load5 = 1'b0;
        cyc = 0;
        while (beats5 < 32 && cyc < 3000) begin
            rd5 = ($urandom_range(0, 9) < 3);
            S5 = ($urandom_range(0, 3) == 0) ? 2'd0 : 2'd3;
            if (rd5 && S5 == 2'd3 && o_valid5) begin
                got5 = {got5[123:0], O5};
                beats5++;
            end
            tick();
            if (done5) dones5++;
            cyc++;
        end
        rd5 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done5) dones5++;
        end
        check("t5_word", got5, word5);
        check("t5_beats", beats5, 32);
        check("t5_dones", dones5, 1);
        check("t5_idle", busy5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
